// File: rtl/lin_rx_frame_store.sv
// lin_rx_frame_store: receive-side LIN frame buffer.
// Takes the byte stream from the LIN byte receiver and checks the PID parity and the checksum.
// Up to 8 data bytes are staged and then committed atomically as two 32-bit words into the
// frame slot selected by id[SLOT_AW-1:0]. The word array is read combinationally by the APB side.
//
// Optional feature macro: LIN_ENHANCED_CHECKSUM_EN
//   defined   -> enhanced (LIN 2.x) checksum: the PID byte is included in the sum,
//                except for IDs 0x3C/0x3D, which always use the classic checksum.
//   undefined -> classic checksum over the data bytes only.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   frame_start      break/sync detected pulse; starts a frame, or restarts one in progress
//   rx_byte/rx_valid received byte and its one-cycle qualifier
//   rx_err           byte receiver error pulse; drops a frame in progress
//   frame_len        data length, sampled with the PID byte (0 or >8 means 8)
//   rd_addr/rd_data  combinational word readback, 0 beyond 2*SLOTS words
//   frame_done, chk_err, pid_err, abort   one-cycle status pulses
//   busy             FSM not idle
//   last_id          ID of the last committed frame
module lin_rx_frame_store #(
  parameter int unsigned SLOTS   = 8,
  parameter int unsigned SLOT_AW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_err,
  input  logic [3:0]  frame_len,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        frame_done,
  output logic        chk_err,
  output logic        pid_err,
  output logic        abort,
  output logic        busy,
  output logic [5:0]  last_id
);

  localparam int unsigned Words = 2 * SLOTS;

  typedef enum logic [2:0] {StIdle, StPid, StData, StChk, StCommit} state_e;

  state_e        state_q, state_d;
  logic [63:0]   stage_q, stage_d;
  logic [3:0]    len_q, len_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [5:0]    id_q, id_d;
  logic [5:0]    last_id_q, last_id_d;
  logic          done_q, done_d, chk_err_q, chk_err_d;
  logic          pid_err_q, pid_err_d, abort_q, abort_d;
  logic [31:0]   mem_q [Words];

  logic          in_frame;
  logic          pid_ok;
  logic [3:0]    eff_len;
  logic [7:0]    sum_init;
  logic [63:0]   commit_data;
  logic [SLOT_AW-1:0] slot;

  // 8-bit add with end-around carry
  function automatic logic [7:0] add_ec(input logic [7:0] s, input logic [7:0] b);
    logic [8:0] t;
    t = {1'b0, s} + {1'b0, b};
    if (t[8]) t = t - 9'h0FF;
    return t[7:0];
  endfunction

  assign in_frame = (state_q == StPid) || (state_q == StData) || (state_q == StChk);
  assign pid_ok   = (rx_byte[6] == (rx_byte[0] ^ rx_byte[1] ^ rx_byte[2] ^ rx_byte[4])) &&
                    (rx_byte[7] == ~(rx_byte[1] ^ rx_byte[3] ^ rx_byte[4] ^ rx_byte[5]));
  assign eff_len  = ((frame_len == 4'd0) || (frame_len > 4'd8)) ? 4'd8 : frame_len;

`ifdef LIN_ENHANCED_CHECKSUM_EN
  // Diagnostic frames always use the classic checksum
  assign sum_init = ((rx_byte[5:0] == 6'h3C) || (rx_byte[5:0] == 6'h3D)) ? 8'h00 : rx_byte;
`else
  assign sum_init = 8'h00;
`endif

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    done_d    = 1'b0;
    chk_err_d = 1'b0;
    pid_err_d = 1'b0;
    abort_d   = 1'b0;
    if (in_frame && frame_start) begin
      // Restart takes precedence over rx_err; only one abort pulse either way
      abort_d = 1'b1;
      stage_d = '1;
      state_d = StPid;
    end else if (in_frame && rx_err) begin
      abort_d = 1'b1;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            stage_d = '1;
            state_d = StPid;
          end
        end
        StPid: begin
          if (rx_valid) begin
            id_d  = rx_byte[5:0];
            len_d = eff_len;
            cnt_d = 3'd0;
            sum_d = sum_init;
            if (pid_ok) begin
              state_d = StData;
            end else begin
              pid_err_d = 1'b1;
              state_d   = StIdle;
            end
          end
        end
        StData: begin
          if (rx_valid) begin
            stage_d[{cnt_q, 3'b000} +: 8] = rx_byte;
            sum_d = add_ec(sum_q, rx_byte);
            cnt_d = cnt_q + 3'd1;
            if (({1'b0, cnt_q} + 4'd1) == len_q) state_d = StChk;
          end
        end
        StChk: begin
          if (rx_valid) begin
            if (add_ec(sum_q, rx_byte) == 8'hFF) begin
              state_d = StCommit;
            end else begin
              chk_err_d = 1'b1;
              state_d   = StIdle;
            end
          end
        end
        StCommit: begin
          done_d    = 1'b1;
          last_id_d = id_q;
          state_d   = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Bytes beyond the frame length always read back as 0xFF
  always_comb begin
    commit_data = '1;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(len_q)) commit_data[8*k +: 8] = stage_q[8*k +: 8];
    end
  end

  assign slot = id_q[SLOT_AW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      stage_q   <= '1;
      len_q     <= 4'd8;
      cnt_q     <= 3'd0;
      sum_q     <= 8'h00;
      id_q      <= 6'd0;
      last_id_q <= 6'd0;
      done_q    <= 1'b0;
      chk_err_q <= 1'b0;
      pid_err_q <= 1'b0;
      abort_q   <= 1'b0;
      for (int i = 0; i < int'(Words); i++) mem_q[i] <= '1;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      done_q    <= done_d;
      chk_err_q <= chk_err_d;
      pid_err_q <= pid_err_d;
      abort_q   <= abort_d;
      if (state_q == StCommit) begin
        mem_q[{slot, 1'b0}] <= commit_data[31:0];
        mem_q[{slot, 1'b1}] <= commit_data[63:32];
      end
    end
  end

  always_comb begin
    rd_data = 32'h0;
    if (rd_addr < Words) rd_data = mem_q[rd_addr[SLOT_AW:0]];
  end

  assign frame_done = done_q;
  assign chk_err    = chk_err_q;
  assign pid_err    = pid_err_q;
  assign abort      = abort_q;
  assign busy       = (state_q != StIdle);
  assign last_id    = last_id_q;

endmodule

// File: tb/tb_lin_rx_frame_store.sv
// Scoreboard bench for lin_rx_frame_store: the stimulus side predicts each status pulse from a
// frame-level model and queues it; a monitor pops and compares whenever a pulse appears.
module tb_lin_rx_frame_store;

`ifdef LIN_ENHANCED_CHECKSUM_EN
  localparam bit Enhanced = 1'b1;
`else
  localparam bit Enhanced = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start, rx_valid, rx_err;
  logic [7:0]  rx_byte;
  logic [3:0]  frame_len;
  logic [31:0] rd_addr, rd_data;
  logic        frame_done, chk_err, pid_err, abort, busy;
  logic [5:0]  last_id;

  always #5 clk = ~clk;

  lin_rx_frame_store #(.SLOTS(8), .SLOT_AW(3)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .frame_start (frame_start),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err),
    .frame_len   (frame_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_done  (frame_done),
    .chk_err     (chk_err),
    .pid_err     (pid_err),
    .abort       (abort),
    .busy        (busy),
    .last_id     (last_id)
  );

  // kind bits: {frame_done, chk_err, pid_err, abort}
  typedef struct {
    logic [3:0] kind;
    logic [5:0] id;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mdl_mem [16];
  logic [5:0]  mdl_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [3:0] kind, input logic [5:0] id);
    ev_t e;
    e.kind = kind;
    e.id   = id;
    exp_q.push_back(e);
  endfunction

  function automatic logic [7:0] ec_add(input logic [7:0] a, input logic [7:0] b);
    int t;
    t = int'(a) + int'(b);
    if (t > 255) t = t - 255;
    return 8'(t);
  endfunction

  function automatic logic [7:0] make_pid(input logic [5:0] id);
    logic p0, p1;
    p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
    p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
    return {p1, p0, id};
  endfunction

  function automatic int eff_len(input logic [3:0] fl);
    return (fl == 4'd0 || fl > 4'd8) ? 8 : int'(fl);
  endfunction

  function automatic logic [7:0] frame_sum(input logic [7:0] pid, input int n,
                                           input logic [63:0] d);
    logic [7:0] s;
    s = 8'h00;
    if (Enhanced && pid[5:0] != 6'h3C && pid[5:0] != 6'h3D) s = pid;
    for (int k = 0; k < n; k++) s = ec_add(s, d[8*k +: 8]);
    return s;
  endfunction

  function automatic logic [7:0] good_chk(input logic [7:0] pid, input logic [3:0] fl,
                                          input logic [63:0] d);
    return ~frame_sum(pid, eff_len(fl), d);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mdl_mem[i] = 32'hFFFF_FFFF;
    mdl_last = 6'd0;
  endfunction

  task automatic drive(input bit fs, input bit v, input logic [7:0] b, input bit e,
                       input logic [3:0] fl);
    @(negedge clk);
    frame_start = fs;
    rx_valid    = v;
    rx_byte     = b;
    rx_err      = e;
    frame_len   = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom), 1'b0, 4'($urandom));
  endtask

  task automatic gap();
    idle(int'($urandom_range(0, 2)));
  endtask

  // err_at: data index replaced by an rx_err pulse; cut_at: data index where sending stops
  // with the frame left open. Use 99 for "never".
  task automatic send_frame(input logic [7:0] pid, input logic [3:0] fl, input logic [63:0] d,
                            input logic [7:0] ck, input int err_at, input int cut_at,
                            input bit start_err);
    int         n;
    bit         ok;
    logic [7:0] s;
    n  = eff_len(fl);
    ok = (pid == make_pid(pid[5:0]));
    drive(1'b1, 1'b0, 8'($urandom), start_err, 4'($urandom));
    gap();
    drive(1'b0, 1'b1, pid, 1'b0, fl);
    if (!ok) push(4'b0010, 6'd0);
    for (int k = 0; k < n; k++) begin
      if (k == cut_at) return;
      gap();
      if (k == err_at) begin
        drive(1'b0, 1'b0, 8'($urandom), 1'b1, 4'($urandom));
        if (ok) push(4'b0001, 6'd0);
        idle(1);
        return;
      end
      drive(1'b0, 1'b1, d[8*k +: 8], 1'b0, 4'($urandom));
    end
    gap();
    drive(1'b0, 1'b1, ck, 1'b0, 4'($urandom));
    if (ok) begin
      s = frame_sum(pid, n, d);
      if (ec_add(s, ck) == 8'hFF) begin
        logic [63:0] w;
        w = '1;
        for (int k = 0; k < n; k++) w[8*k +: 8] = d[8*k +: 8];
        push(4'b1000, pid[5:0]);
        mdl_mem[2*int'(pid[2:0])]     = w[31:0];
        mdl_mem[2*int'(pid[2:0]) + 1] = w[63:32];
        mdl_last = pid[5:0];
      end else begin
        push(4'b0100, 6'd0);
      end
    end
    idle(1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_mem();
    for (int a = 0; a < 18; a++) begin
      rd_addr = 32'(a);
      #1;
      chk($sformatf("word%0d", a), 64'(rd_data), (a < 16) ? 64'(mdl_mem[a]) : 64'd0);
    end
    rd_addr = 32'h8000_0000 | 32'($urandom);
    #1;
    chk("word_far", 64'(rd_data), 64'd0);
    chk("last_id", 64'(last_id), 64'(mdl_last));
  endtask

  task automatic check_word(input string name, input int a, input logic [31:0] v);
    rd_addr = 32'(a);
    #1;
    chk(name, 64'(rd_data), 64'(v));
  endtask

  // Monitor: every status pulse must match the oldest predicted event
  logic [3:0] obs;
  ev_t        got;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        obs = {frame_done, chk_err, pid_err, abort};
        if (obs != 4'b0000) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", 64'(obs), 64'd0);
          end else begin
            got = exp_q.pop_front();
            chk("event_kind", 64'(obs), 64'(got.kind));
            if (got.kind[3]) chk("event_last_id", 64'(last_id), 64'(got.id));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pid, ck;
    logic [3:0]  fl;
    logic [63:0] d;
    int          n, err_at;
    rst_n = 1'b0;
    frame_start = 1'b0;
    rx_valid = 1'b0;
    rx_err = 1'b0;
    rx_byte = 8'h00;
    frame_len = 4'd0;
    rd_addr = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_pulses", 64'({frame_done, chk_err, pid_err, abort}), 64'd0);
    check_mem();
    rst_n = 1'b1;
    idle(2);

    // rx_valid and rx_err in idle are ignored
    drive(1'b0, 1'b1, 8'h25, 1'b0, 4'd2);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 4'd2);
    idle(2);
    chk("idle_busy", 64'(busy), 64'd0);

    // Good frame
    d = 64'h2211;
    send_frame(8'h25, 4'd2, d, good_chk(8'h25, 4'd2, d), 99, 99, 1'b0);
    drain();
    check_word("good_w10", 10, 32'hFFFF_2211);
    check_word("good_w11", 11, 32'hFFFF_FFFF);
    chk("good_last_id", 64'(last_id), 64'h25);

    // Explicit classic and enhanced checksums for the same frame
    send_frame(8'h25, 4'd2, d, 8'hCC, 99, 99, 1'b0);
    drain();
    send_frame(8'h25, 4'd2, d, 8'hA7, 99, 99, 1'b0);
    drain();
    check_mem();

    // End-around carry
    d = 64'h20F0;
    send_frame(8'h25, 4'd2, d, good_chk(8'h25, 4'd2, d), 99, 99, 1'b0);
    drain();
    check_word("carry_w10", 10, 32'hFFFF_20F0);

    // Parity failure; remaining bytes are ignored
    send_frame(8'hA5, 4'd2, 64'h5566, 8'h44, 99, 99, 1'b0);
    drain();
    check_mem();

    // rx_err after the 3rd of 8 bytes
    d = {$urandom, $urandom};
    send_frame(make_pid(6'h12), 4'd8, d, 8'h00, 3, 99, 1'b0);
    drain();
    chk("err_busy", 64'(busy), 64'd0);
    check_mem();

    // frame_start mid-DATA restarts, next frame commits
    send_frame(make_pid(6'h07), 4'd6, d, 8'h00, 99, 2, 1'b0);
    push(4'b0001, 6'd0);
    d = {$urandom, $urandom};
    send_frame(make_pid(6'h07), 4'd5, d, good_chk(make_pid(6'h07), 4'd5, d), 99, 99, 1'b0);
    drain();
    check_mem();

    // frame_start together with rx_err: one abort, restart wins
    send_frame(make_pid(6'h3C), 4'd8, d, 8'h00, 99, 4, 1'b0);
    push(4'b0001, 6'd0);
    send_frame(make_pid(6'h3C), 4'd3, d, good_chk(make_pid(6'h3C), 4'd3, d), 99, 99, 1'b1);
    drain();
    check_mem();

    // frame_len 0 means 8 bytes
    d = {$urandom, $urandom};
    send_frame(make_pid(6'h21), 4'd0, d, good_chk(make_pid(6'h21), 4'd0, d), 99, 99, 1'b0);
    drain();
    check_mem();

    // Reset mid-DATA
    send_frame(make_pid(6'h2A), 4'd8, d, 8'h00, 99, 3, 1'b0);
    idle(1);
    chk("mid_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    check_mem();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("rst_idle", 64'(busy), 64'd0);

    // Randomized frames
    for (int i = 0; i < 150; i++) begin
      pid = ($urandom_range(0, 9) < 7) ? make_pid(6'($urandom)) : 8'($urandom);
      fl  = 4'($urandom);
      d   = {$urandom, $urandom};
      n   = eff_len(fl);
      ck  = ($urandom_range(0, 3) != 0) ? good_chk(pid, fl, d) : 8'($urandom);
      err_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, n - 1)) : 99;
      send_frame(pid, fl, d, ck, err_at, 99, 1'b0);
      drain();
      if (i % 10 == 9) check_mem();
    end
    check_mem();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
